mem_arbiter_n: RTL and testbench

Parametrised N-port line-to-burst memory arbiter. It sits between the cache-side miss paths (L2 caches, eviction buffer, prefetcher) and the single burst-mode physical memory port. Each client issues whole-line read or write requests. The block grants one client at a time using a round-robin or fixed-priority policy, serialises the line into `LINE_W/BEAT_W` memory beats, reassembles read beats into a line, and pulses a per-port response.

---
 rtl/mem_arbiter_n.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter_n.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: N-port line-to-burst memory arbiter.
// Grants one client at a time (round-robin or fixed priority), splits the
// line into BEATS memory beats on a burst port, reassembles read beats
// into a line and pulses a one-hot per-port completion.
module mem_arbiter_n #(
  parameter int NUM_PORTS = 2,
  parameter int LINE_W    = 256,
  parameter int BEAT_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int MODE      = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
  output logic [LINE_W-1:0]           req_rdata,
  output logic [NUM_PORTS-1:0]        req_resp,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [ADDR_W-1:0]           pmem_addr,
  output logic [BEAT_W-1:0]           pmem_wdata,
  input  logic [BEAT_W-1:0]           pmem_rdata,
  input  logic                        pmem_resp
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GNT_W = $clog2(NUM_PORTS);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t             state_reg;
  logic [GNT_W-1:0]   grant_reg;
  logic [GNT_W-1:0]   last_grant_reg;
  logic               op_write_reg;
  logic [CNT_W-1:0]   beat_cnt_reg;
  logic [LINE_W-1:0]  line_reg;
  logic [BEAT_W-1:0]  rbuf_reg [BEATS];

  logic [NUM_PORTS-1:0] req_vec;
  logic [GNT_W-1:0]     grant_next;
  logic                 found;
  int                   rr_idx;

  logic [ADDR_W-1:0] port_addr  [NUM_PORTS];
  logic [LINE_W-1:0] port_wdata [NUM_PORTS];
  logic [BEAT_W-1:0] line_beat  [BEATS];
  logic [LINE_W-1:0] merged_line;

  assign req_vec = req_read | req_write;

  // Unpack the flat per-port buses into indexable arrays.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign port_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign port_wdata[gi] = req_wdata[gi*LINE_W +: LINE_W];
  end

  // Beat view of the latched write line, and the read line with the
  // in-flight beat merged in so the final beat lands in req_rdata directly.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    assign line_beat[gi] = line_reg[gi*BEAT_W +: BEAT_W];
    assign merged_line[gi*BEAT_W +: BEAT_W] =
      (beat_cnt_reg == CNT_W'(gi)) ? pmem_rdata : rbuf_reg[gi];
  end

  // Grant selection: rotating search after last_grant, or lowest index.
  always_comb begin
    grant_next = last_grant_reg;
    found      = 1'b0;
    rr_idx     = 0;
    if (MODE == 0) begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        rr_idx = int'(last_grant_reg) + k;
        if (rr_idx >= NUM_PORTS) rr_idx = rr_idx - NUM_PORTS;
        if (!found && req_vec[GNT_W'(rr_idx)]) begin
          found      = 1'b1;
          grant_next = GNT_W'(rr_idx);
        end
      end
    end else begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        if (req_vec[GNT_W'(k)]) grant_next = GNT_W'(k);
      end
    end
  end

  // Arbitration / burst FSM with all client and memory outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GNT_W'(NUM_PORTS - 1);
      op_write_reg   <= 1'b0;
      beat_cnt_reg   <= '0;
      line_reg       <= '0;
      for (int i = 0; i < BEATS; i++) rbuf_reg[i] <= '0;
      pmem_read      <= 1'b0;
      pmem_write     <= 1'b0;
      pmem_addr      <= '0;
      pmem_wdata     <= '0;
      req_resp       <= '0;
      req_rdata      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req_vec) begin
            // A port asserting both read and write gets the write.
            grant_reg    <= grant_next;
            op_write_reg <= req_write[grant_next];
            pmem_read    <= ~req_write[grant_next];
            pmem_write   <= req_write[grant_next];
            pmem_addr    <= port_addr[grant_next] & LINE_MASK;
            beat_cnt_reg <= '0;
            if (req_write[grant_next]) begin
              line_reg   <= port_wdata[grant_next];
              pmem_wdata <= port_wdata[grant_next][BEAT_W-1:0];
            end else begin
              line_reg   <= '0;
              pmem_wdata <= '0;
            end
            state_reg <= BURST;
          end
        end
        BURST: begin
          if (pmem_resp) begin
            if (!op_write_reg) rbuf_reg[beat_cnt_reg] <= pmem_rdata;
            if (beat_cnt_reg == LAST_BEAT) begin
              pmem_read    <= 1'b0;
              pmem_write   <= 1'b0;
              pmem_wdata   <= '0;
              beat_cnt_reg <= '0;
              req_resp     <= NUM_PORTS'(1) << grant_reg;
              if (!op_write_reg) req_rdata <= merged_line;
              state_reg    <= DONE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
              if (op_write_reg) pmem_wdata <= line_beat[beat_cnt_reg + CNT_W'(1)];
            end
          end
        end
        DONE: begin
          req_resp       <= '0;
          last_grant_reg <= grant_reg;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n: two arbiters (4 ports, round-robin and fixed priority)
// driven by directed and randomized client traffic and a behavioural
// memory; expectations come from a transaction-level model of the rules.
module tb_mem_arbiter_n;

  localparam int NP = 4;
  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int NB = LW / BW;

  logic clk = 1'b0;
  logic rst;

  logic [NP-1:0]    rd [2];
  logic [NP-1:0]    wr [2];
  logic [NP*AW-1:0] addr_bus [2];
  logic [NP*LW-1:0] wdata_bus [2];
  logic [LW-1:0]    rdata_o [2];
  logic [NP-1:0]    resp_o [2];
  logic             pr_o [2];
  logic             pw_o [2];
  logic [AW-1:0]    pa_o [2];
  logic [BW-1:0]    pwd_o [2];
  logic [BW-1:0]    prd [2];
  logic             presp [2];

  // Transaction-level model state.
  logic [AW-1:0] c_addr [2][NP];
  logic [LW-1:0] c_line [2][NP];
  int            last_g [2];
  logic [LW-1:0] exp_rdata [2];
  int            mode_of [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter_n #(.NUM_PORTS(NP), .LINE_W(LW), .BEAT_W(BW), .ADDR_W(AW), .MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .req_read(rd[0]), .req_write(wr[0]), .req_addr(addr_bus[0]), .req_wdata(wdata_bus[0]),
    .req_rdata(rdata_o[0]), .req_resp(resp_o[0]),
    .pmem_read(pr_o[0]), .pmem_write(pw_o[0]), .pmem_addr(pa_o[0]), .pmem_wdata(pwd_o[0]),
    .pmem_rdata(prd[0]), .pmem_resp(presp[0])
  );

  mem_arbiter_n #(.NUM_PORTS(NP), .LINE_W(LW), .BEAT_W(BW), .ADDR_W(AW), .MODE(1)) u_fp (
    .clk(clk), .rst(rst),
    .req_read(rd[1]), .req_write(wr[1]), .req_addr(addr_bus[1]), .req_wdata(wdata_bus[1]),
    .req_rdata(rdata_o[1]), .req_resp(resp_o[1]),
    .pmem_read(pr_o[1]), .pmem_write(pw_o[1]), .pmem_addr(pa_o[1]), .pmem_wdata(pwd_o[1]),
    .pmem_rdata(prd[1]), .pmem_resp(presp[1])
  );

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Expected grant from the arbitration rule, -1 when nobody requests.
  function automatic int pick(input int d, input logic [NP-1:0] v);
    if (mode_of[d] == 1) begin
      for (int i = 0; i < NP; i++) if (v[i]) return i;
    end else begin
      for (int k = 1; k <= NP; k++) if (v[(last_g[d] + k) % NP]) return (last_g[d] + k) % NP;
    end
    return -1;
  endfunction

  task automatic set_req(input int d, input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [LW-1:0] line);
    rd[d][p] = r;
    wr[d][p] = w;
    c_addr[d][p] = a;
    c_line[d][p] = line;
    addr_bus[d][p*AW +: AW] = a;
    wdata_bus[d][p*LW +: LW] = line;
  endtask

  task automatic set_rand_req(input int d, input int p);
    int op;
    op = int'($urandom_range(0, 2));
    set_req(d, p, op != 1, op != 0, $urandom, rand_line());
  endtask

  task automatic chk_reset(input int d);
    chk("rst_pmem_read", pr_o[d], 0);
    chk("rst_pmem_write", pw_o[d], 0);
    chk("rst_pmem_addr", pa_o[d], 0);
    chk("rst_pmem_wdata", pwd_o[d], 0);
    chk("rst_req_resp", resp_o[d], 0);
    chk("rst_req_rdata", rdata_o[d], 0);
  endtask

  // One whole transaction. Entered at a negedge of an IDLE cycle with the
  // request vector already driven; returns at the negedge of the next IDLE
  // cycle. wmode < 0 draws 0..3 wait cycles per beat, otherwise fixed.
  task automatic do_round(input int d, input int wmode, input bit pat, output int g);
    logic [NP-1:0] v;
    logic          isw;
    logic [AW-1:0] ea;
    logic [LW-1:0] line;
    logic [LW-1:0] got;
    logic [BW-1:0] beat;
    int            wk;
    v    = rd[d] | wr[d];
    g    = pick(d, v);
    chk("has_request", v != 0, 1);
    if (g < 0) g = 0;
    isw  = wr[d][g];
    ea   = c_addr[d][g] & ~32'h1F;
    line = c_line[d][g];
    got  = '0;
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < NB; k++) begin
      wk = (wmode < 0) ? int'($urandom_range(0, 3)) : wmode;
      for (int w = 0; w <= wk; w++) begin
        chk("pmem_read", pr_o[d], !isw);
        chk("pmem_write", pw_o[d], isw);
        chk("pmem_addr", pa_o[d], ea);
        if (isw) chk("pmem_wdata", pwd_o[d], line[k*BW +: BW]);
        chk("resp_in_burst", resp_o[d], 0);
        if (w == wk) begin
          beat = pat ? {16{4'(k + 1)}} : {$urandom, $urandom};
          prd[d] = beat;
          got[k*BW +: BW] = beat;
          presp[d] = 1'b1;
        end
        @(posedge clk); @(negedge clk);
        presp[d] = 1'b0;
      end
    end
    if (!isw) exp_rdata[d] = got;
    chk("req_resp", resp_o[d], NP'(1) << g);
    chk("req_rdata", rdata_o[d], exp_rdata[d]);
    chk("done_pmem_read", pr_o[d], 0);
    chk("done_pmem_write", pw_o[d], 0);
    $display("txn dut=%0d port=%0d op=%s addr=%h line=%h", d, g, isw ? "WR" : "RD", ea,
             isw ? line : got);
    last_g[d] = g;
    rd[d][g] = 1'b0;
    wr[d][g] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("resp_cleared", resp_o[d], 0);
    chk("idle_pmem_op", pr_o[d] | pw_o[d], 0);
  endtask

  task automatic drain(input int d);
    int g;
    while ((rd[d] | wr[d]) != 0) do_round(d, -1, 1'b0, g);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    int rr4_seq[5] = '{0, 1, 2, 3, 0};
    int rr2_seq[4] = '{0, 1, 0, 1};
    int fp_seq[4]  = '{0, 0, 0, 1};
    logic [LW-1:0] hold;

    rst = 1'b0;
    mode_of[0] = 0;
    mode_of[1] = 1;
    for (int d = 0; d < 2; d++) begin
      rd[d] = '0; wr[d] = '0; addr_bus[d] = '0; wdata_bus[d] = '0;
      prd[d] = '0; presp[d] = 1'b0;
      last_g[d] = NP - 1;
      exp_rdata[d] = '0;
      for (int p = 0; p < NP; p++) begin c_addr[d][p] = '0; c_line[d][p] = '0; end
    end
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst = 1'b1;
    @(negedge clk);

    // Four ports requesting continuously, round-robin.
    for (int p = 0; p < NP; p++) set_rand_req(0, p);
    for (int r = 0; r < 5; r++) begin
      do_round(0, 0, 1'b0, g);
      chk("rr4_order", g, rr4_seq[r]);
      if (r < 4) set_rand_req(0, g);
    end
    drain(0);

    // Single read, zero-wait memory, patterned beats.
    set_req(0, 0, 1'b1, 1'b0, 32'h0000_1234, '0);
    do_round(0, 0, 1'b1, g);
    chk("read_port", g, 0);
    chk("read_line", rdata_o[0] | exp_rdata[0],
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // Single write on port 1 with three wait cycles per beat.
    set_req(0, 1, 1'b0, 1'b1, 32'h0000_8040,
            256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA);
    do_round(0, 3, 1'b0, g);
    chk("write_port", g, 1);

    // Two ports contending, round-robin.
    set_rand_req(0, 0);
    set_rand_req(0, 1);
    for (int r = 0; r < 4; r++) begin
      do_round(0, -1, 1'b0, g);
      chk("rr2_order", g, rr2_seq[r]);
      if (r < 3) set_rand_req(0, g);
    end
    drain(0);

    // Two ports contending, fixed priority; port 0 stops after three grants.
    set_rand_req(1, 0);
    set_rand_req(1, 1);
    for (int r = 0; r < 4; r++) begin
      do_round(1, -1, 1'b0, g);
      chk("fp_order", g, fp_seq[r]);
      if (r < 2 && g == 0) set_rand_req(1, 0);
    end
    drain(1);

    // Illegal read+write on one port performs the write.
    set_req(1, 0, 1'b1, 1'b1, $urandom, rand_line());
    @(posedge clk); @(negedge clk);
    chk("illegal_is_write", {pr_o[1], pw_o[1]}, 2'b01);
    // That cycle is now the first burst cycle; finish it through the model.
    for (int k = 0; k < NB; k++) begin
      chk("illegal_wdata", pwd_o[1], c_line[1][0][k*BW +: BW]);
      presp[1] = 1'b1;
      @(posedge clk); @(negedge clk);
      presp[1] = 1'b0;
    end
    chk("illegal_resp", resp_o[1], 4'b0001);
    last_g[1] = 0;
    rd[1][0] = 1'b0; wr[1][0] = 1'b0;
    @(posedge clk); @(negedge clk);

    // Spurious pmem_resp while idle changes nothing.
    hold = exp_rdata[1];
    for (int i = 0; i < 3; i++) begin
      prd[1] = {$urandom, $urandom};
      presp[1] = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("spurious_op", pr_o[1] | pw_o[1], 0);
      chk("spurious_resp", resp_o[1], 0);
      chk("spurious_rdata", rdata_o[1], hold);
    end
    presp[1] = 1'b0;
    set_req(1, 3, 1'b1, 1'b0, $urandom, '0);
    do_round(1, -1, 1'b0, g);

    // Reset after two beats of a write, then the held request restarts.
    set_req(0, 2, 1'b0, 1'b1, $urandom, rand_line());
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      presp[0] = 1'b1;
      @(posedge clk); @(negedge clk);
      presp[0] = 1'b0;
    end
    chk("pre_reset_wdata", pwd_o[0], c_line[0][2][2*BW +: BW]);
    rst = 1'b0;
    #1;
    chk_reset(0);
    chk_reset(1);
    last_g[0] = NP - 1; last_g[1] = NP - 1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    @(negedge clk);
    rst = 1'b1;
    do_round(0, -1, 1'b0, g);
    chk("restart_port", g, 2);

    // Randomized traffic on both arbiters.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 16; n++) begin
        for (int p = 0; p < NP; p++)
          if (!(rd[d][p] | wr[d][p]) && $urandom_range(0, 1) == 1) set_rand_req(d, p);
        if ((rd[d] | wr[d]) == 0) set_rand_req(d, int'($urandom_range(0, NP - 1)));
        do_round(d, -1, 1'b0, g);
      end
      drain(d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
